// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/write-back bus of the scoreboarded register file
// Signals:
//   rd_en, rd_addr1, rd_addr2          read request and the two read addresses
//   rd_data1, rd_data2, rd_busy1/2     registered read data and busy bits
//   rd_valid                           one-cycle pulse marking fresh read results
//   wr_en, wr_addr, wr_data            write-back commit (clears busy)
//   iss_en, iss_addr                   issue: mark destination register busy
// Modports: master (decode/write-back side), slave (register file).
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;

    modport master (
        output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, rd_valid
    );

    modport slave (
        input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, rd_valid
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with registered reads and a per-register busy scoreboard
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset; clears array, busy bits and all read outputs
//   bus     regfile_sb_if.slave (read, write-back and issue signals)
// Parameters: DATA_W (register width), ADDR_W (depth = 2^ADDR_W),
//   ZERO_REG (1: register 0 reads 0, ignores writes, never busy).
// Build option: REGFILE_BYPASS_EN -- same-edge reads see the write/issue of that edge;
//   without it they see the pre-edge state.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic         clk_i,
    input logic         rst_ni,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d, busy_rd;
    logic              wr_ok, iss_ok, byp1, byp2, zero1, zero2;
    logic [DATA_W-1:0] data1_d, data2_d, data1_q, data2_q;
    logic              busy1_d, busy2_d, busy1_q, busy2_q, valid_q;

    assign wr_ok  = bus.wr_en  && !(ZR && bus.wr_addr  == '0);
    assign iss_ok = bus.iss_en && !(ZR && bus.iss_addr == '0);
    assign zero1  = ZR && bus.rd_addr1 == '0;
    assign zero2  = ZR && bus.rd_addr2 == '0;

    // Issue is applied after the write so a new producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) busy_d[bus.wr_addr] = 1'b0;
        if (iss_ok) busy_d[bus.iss_addr] = 1'b1;
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1    = wr_ok && bus.wr_addr == bus.rd_addr1;
    assign byp2    = wr_ok && bus.wr_addr == bus.rd_addr2;
    assign busy_rd = busy_d;
`else
    assign byp1    = 1'b0;
    assign byp2    = 1'b0;
    assign busy_rd = busy_q;
`endif

    always_comb begin
        data1_d = zero1 ? '0 : byp1 ? bus.wr_data : mem_q[bus.rd_addr1];
        data2_d = zero2 ? '0 : byp2 ? bus.wr_data : mem_q[bus.rd_addr2];
        busy1_d = !zero1 && busy_rd[bus.rd_addr1];
        busy2_d = !zero2 && busy_rd[bus.rd_addr2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            busy1_q <= 1'b0;
            busy2_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
            busy_q  <= busy_d;
            valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                data1_q <= data1_d;
                data2_q <= data2_d;
                busy1_q <= busy1_d;
                busy2_q <= busy2_d;
            end
        end
    end

    assign bus.rd_data1 = data1_q;
    assign bus.rd_data2 = data2_q;
    assign bus.rd_busy1 = busy1_q;
    assign bus.rd_busy2 = busy2_q;
    assign bus.rd_valid = valid_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb (32x32 default instance plus 8x16 instance)
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t last = '{d1: 0, b1: 0, d2: 0, b2: 0};

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) c  ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_rf (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_rf16 (.clk_i(clk), .rst_ni(rst_n), .bus(c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b0.rd_en = 0; b0.rd_addr1 = 0; b0.rd_addr2 = 0;
        b0.wr_en = 0; b0.wr_addr = 0; b0.wr_data = 0;
        b0.iss_en = 0; b0.iss_addr = 0;
        c.rd_en = 0; c.rd_addr1 = 0; c.rd_addr2 = 0;
        c.wr_en = 0; c.wr_addr = 0; c.wr_data = 0;
        c.iss_en = 0; c.iss_addr = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        b0.wr_en = 1; b0.wr_addr = a; b0.wr_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        b0.iss_en = 1; b0.iss_addr = a;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] d1, input logic bb1,
                      input logic [31:0] d2, input logic bb2);
        b0.rd_en = 1; b0.rd_addr1 = a1; b0.rd_addr2 = a2;
        exp_q.push_back('{d1: d1, b1: bb1, d2: d2, b2: bb2});
    endtask

    task automatic check_out(input string tag, input logic v);
        chk({tag, ".rd_valid"}, b0.rd_valid, v);
        chk({tag, ".rd_data1"}, b0.rd_data1, last.d1);
        chk({tag, ".rd_busy1"}, b0.rd_busy1, last.b1);
        chk({tag, ".rd_data2"}, b0.rd_data2, last.d2);
        chk({tag, ".rd_busy2"}, b0.rd_busy2, last.b2);
    endtask

    // One clock: a queued expectation means a read was issued this cycle, so rd_valid
    // must pulse with that result; otherwise rd_valid is low and outputs hold.
    task automatic step(input string tag);
        logic v;
        @(posedge clk);
        #1;
        v = exp_q.size() != 0;
        if (v) last = exp_q.pop_front();
        check_out(tag, v);
        idle();
    endtask

    initial begin
        idle();
        #1;
        check_out("reset", 1'b0);
        #13 rst_n = 1;

        // dirty state, then mid-cycle reset pulse, then cold read
        wr(5, 32'h0000_1234); iss(31); step("dirty");
        #3 rst_n = 0;
        #2 rst_n = 1;
        rd(5, 31, 0, 0, 0, 0); step("cold");

        // zero register
        wr(0, 32'hDEAD_BEEF); iss(0); step("w0");
        rd(0, 0, 0, 0, 0, 0); step("r0");
        wr(7, 32'h1234_5678); step("w7");
        rd(7, 0, 32'h1234_5678, 0, 0, 0); step("r7");
        step("hold");

        // scoreboard
        iss(9); step("iss9");
        rd(9, 7, 0, 1, 32'h1234_5678, 0); step("r9busy");
        wr(9, 32'hA5A5_A5A5); step("w9");
        rd(9, 9, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5, 0); step("r9clr");
        wr(9, 32'h0000_0077); iss(9); step("wi9");
        rd(9, 0, 32'h0000_0077, 1, 0, 0); step("r9wi");
        wr(9, 32'h0000_0088);
        rd(9, 7, BYP ? 32'h88 : 32'h77, BYP ? 1'b0 : 1'b1, 32'h1234_5678, 0); step("rw9same");
        rd(9, 9, 32'h88, 0, 32'h88, 0); step("r9after");

        // same-edge write/read bypass
        wr(3, 32'h11); step("w3");
        wr(3, 32'h22);
        rd(3, 3, BYP ? 32'h22 : 32'h11, 0, BYP ? 32'h22 : 32'h11, 0); step("byp3");
        rd(3, 9, 32'h22, 0, 32'h88, 0); step("r3after");
        iss(9);
        rd(9, 3, 32'h88, BYP, 32'h22, 0); step("iss9same");

        // reset mid-operation
        iss(4); wr(6, 32'h55); step("iw46");
        rd(4, 6, 0, 1, 32'h55, 0); step("r46");
        #2 rst_n = 0;
        #1;
        last = '{d1: 0, b1: 0, d2: 0, b2: 0};
        check_out("async_rst", 1'b0);
        #2 rst_n = 1;
        step("post_rst");
        rd(4, 6, 0, 0, 0, 0); step("r46rst");

        // 8x16 instance: every entry independent, 0xBEEF lands at address 7
        for (int i = 0; i < 8; i++) begin
            c.wr_en = 1; c.wr_addr = 3'(i); c.wr_data = 16'hBEE8 + 16'(i);
            step("w16");
        end
        for (int i = 0; i < 8; i++) begin
            c.rd_en = 1; c.rd_addr1 = 3'(i); c.rd_addr2 = 3'd7;
            step("r16");
            chk("w16.rd_valid", c.rd_valid, 1);
            chk("w16.rd_data1", c.rd_data1, i == 0 ? 16'h0 : 16'hBEE8 + 16'(i));
            chk("w16.rd_data2", c.rd_data2, 16'hBEEF);
            chk("w16.rd_busy1", c.rd_busy1, 0);
        end
        step("w16idle");
        chk("w16.valid_drop", c.rd_valid, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
